// File: rtl/regfile_writeback.sv
// Writeback sequencer: merges ALU and load-unit results into a shared FIFO
// and drains up to two hazard-free writes per cycle. Option: WB_PENDING_MASK_EN.
module regfile_writeback #(
    parameter int DEPTH = 4,
    parameter int AW    = 4,
    parameter int DW    = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          a_valid,
    output logic          a_ready,
    input  logic [AW-1:0] a_sel,
    input  logic [DW-1:0] a_data,
    input  logic          b_valid,
    output logic          b_ready,
    input  logic [AW-1:0] b_sel,
    input  logic [DW-1:0] b_data,
    output logic          wr1_we,
    output logic [AW-1:0] wr1_sel,
    output logic [DW-1:0] wr1_data,
    output logic          wr2_we,
    output logic [AW-1:0] wr2_sel,
    output logic [DW-1:0] wr2_data,
    output logic          idle
`ifdef WB_PENDING_MASK_EN
    ,
    output logic [2**AW-1:0] pending
`endif
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [AW-1:0] sel_q  [DEPTH];
    logic [DW-1:0] data_q [DEPTH];

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;

    logic [CW-1:0] space;
    logic          push_a;
    logic          push_b;
    logic [PW-1:0] head1;
    logic [PW-1:0] b_idx;
    logic          issue1;
    logic          issue2;
    logic [CW-1:0] n_push;
    logic [CW-1:0] n_pop;

    // Ready looks only at the registered count, never at this cycle's pops.
    assign space   = DEPTH_C - count;
    assign a_ready = space >= CW'(1);
    assign b_ready = space >= CW'(2);

    assign push_a = a_valid && a_ready;
    assign push_b = b_valid && b_ready;

    always_comb begin
        head1  = head + PW'(1);
        b_idx  = push_a ? tail + PW'(1) : tail;
        issue1 = count != '0;
        issue2 = (count >= CW'(2)) && (sel_q[head1] != sel_q[head]);
        n_push = CW'(push_a) + CW'(push_b);
        n_pop  = '0;
        if (issue2) begin
            n_pop = CW'(2);
        end else if (issue1) begin
            n_pop = CW'(1);
        end
    end

    // Storage needs no reset: only entries below count are ever read.
    always_ff @(posedge clk) begin
        if (push_a) begin
            sel_q[tail]  <= a_sel;
            data_q[tail] <= a_data;
        end
        if (push_b) begin
            sel_q[b_idx]  <= b_sel;
            data_q[b_idx] <= b_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PW'(n_pop);
            tail  <= tail + PW'(n_push);
            count <= count + n_push - n_pop;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr1_we   <= 1'b0;
            wr1_sel  <= '0;
            wr1_data <= '0;
            wr2_we   <= 1'b0;
            wr2_sel  <= '0;
            wr2_data <= '0;
        end else begin
            wr1_we <= issue1;
            wr2_we <= issue2;
            if (issue1) begin
                wr1_sel  <= sel_q[head];
                wr1_data <= data_q[head];
            end
            if (issue2) begin
                wr2_sel  <= sel_q[head1];
                wr2_data <= data_q[head1];
            end
        end
    end

    assign idle = (count == '0) && !wr1_we && !wr2_we;

`ifdef WB_PENDING_MASK_EN
    always_comb begin
        pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) < count) begin
                pending[sel_q[head + PW'(i)]] = 1'b1;
            end
        end
        if (wr1_we) begin
            pending[wr1_sel] = 1'b1;
        end
        if (wr2_we) begin
            pending[wr2_sel] = 1'b1;
        end
    end
`endif

endmodule
